// File: rtl/sd_data_pkg.sv
// Shared types and constants for the SD sector read-back path.
package sd_data_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RECV,
    DRAIN
  } sdr_state_t;

  localparam int          SECTOR_BYTES     = 512;
  localparam logic [15:0] CNT_WAIT_MAX_DEF = 16'd60000;

endpackage

// File: rtl/sdr_byte_fifo.sv
// Single-clock byte FIFO. Up to two bytes can be written per cycle (port a is
// the older byte, port b the younger) so a word splitter can keep up with
// back-to-back 16-bit words. Async reset and i_flush both empty it.
module sdr_byte_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push_a,
  input  logic [7:0]                   i_data_a,
  input  logic                         i_push_b,
  input  logic [7:0]                   i_data_b,
  input  logic                         i_pop,
  output logic [7:0]                   o_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_ptr_b;
  logic          w_acc_a;
  logic          w_acc_b;
  logic          w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Accept each byte only if there is room for it after the older one.
  always_comb begin
    w_acc_a    = i_push_a && !i_flush && (r_count != FULL_CNT);
    w_acc_b    = i_push_b && !i_flush && ((r_count + CW'(w_acc_a)) < FULL_CNT);
    w_pop      = i_pop && !i_flush && (r_count != '0);
    w_wr_ptr_b = w_acc_a ? ptr_inc(r_wr_ptr) : r_wr_ptr;
  end

  // Storage array; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_acc_a) r_mem[r_wr_ptr]   <= i_data_a;
    if (w_acc_b) r_mem[w_wr_ptr_b] <= i_data_b;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_acc_b)      r_wr_ptr <= ptr_inc(w_wr_ptr_b);
      else if (w_acc_a) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)        r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_acc_a) + CW'(w_acc_b) - CW'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;

endmodule

// File: rtl/sd_sector_reader.sv
// SD sector read-back: requests one sector from the SD read controller,
// splits the 16-bit words into bytes (high byte first), buffers them and
// paces them out to uart_tx as o_tx_flag/o_tx_data strobes.
// Optional feature macro: SDR_AUTO_INC_EN (continuous reading of consecutive
// sectors until a start pulse or an error stops it).
//
//   state | meaning
//   IDLE  | waiting for start with init_end
//   REQ   | one-cycle rd_en to the SD controller
//   WAIT  | waiting for rd_busy, bounded by BUSY_TIMEOUT
//   RECV  | collecting words until rd_busy falls
//   DRAIN | waiting for buffer and pacing to empty, then done
module sd_sector_reader
  import sd_data_pkg::*;
#(
  parameter int          WORDS_PER_SECTOR = 256,
  parameter int          BUF_DEPTH        = SECTOR_BYTES,
  parameter logic [15:0] CNT_WAIT_MAX     = CNT_WAIT_MAX_DEF,
  parameter logic [23:0] BUSY_TIMEOUT     = 24'd5000000
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_init_end,
  input  logic        i_start,
  input  logic [31:0] i_start_addr,
  output logic        o_rd_en,
  output logic [31:0] o_rd_addr,
  input  logic        i_rd_busy,
  input  logic        i_rd_data_en,
  input  logic [15:0] i_rd_data,
  output logic        o_tx_flag,
  output logic [7:0]  o_tx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int            CW          = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] CNT_ONE_LEFT = CW'(BUF_DEPTH - 1);
  localparam logic [15:0]   WORDS_EXP   = 16'(WORDS_PER_SECTOR);

  sdr_state_t    r_state, w_state_nxt;
  logic [31:0]   r_rd_addr;
  logic [23:0]   r_tmo;
  logic [15:0]   r_word_cnt;
  logic          r_busy_d;
  logic [7:0]    r_lo;
  logic          r_lo_vld;
  logic [15:0]   r_cnt_wait;
  logic          r_tx_flag;
  logic [7:0]    r_tx_data;
  logic          r_err;
`ifdef SDR_AUTO_INC_EN
  logic          r_stop;
`endif

  logic          w_accept, w_word_en, w_fall, w_cnt_bad, w_timeout;
  logic          w_push_a, w_push_b, w_pop, w_drop, w_drain_done, w_done;
  logic [7:0]    w_data_a, w_data_b, w_fifo_data;
  logic          w_fifo_empty, w_fifo_full;
  logic [CW-1:0] w_fifo_count;
  logic [15:0]   w_wcnt_nxt;

  assign w_accept   = (r_state == IDLE) && i_start && i_init_end;
  assign w_word_en  = (r_state == RECV) && i_rd_data_en;
  assign w_fall     = r_busy_d && !i_rd_busy;
  assign w_wcnt_nxt = r_word_cnt + 16'(w_word_en);
  assign w_cnt_bad  = (r_state == RECV) && w_fall && (w_wcnt_nxt != WORDS_EXP);
  assign w_timeout  = (r_state == WAIT) && !i_rd_busy && (r_tmo == '0);

  // A pending low byte always goes first; a new high byte rides behind it.
  assign w_push_a = r_lo_vld || w_word_en;
  assign w_data_a = r_lo_vld ? r_lo : i_rd_data[15:8];
  assign w_push_b = r_lo_vld && w_word_en;
  assign w_data_b = i_rd_data[15:8];
  assign w_drop   = (w_push_a && w_fifo_full) ||
                    (w_push_b && (w_fifo_full || (w_fifo_count == CNT_ONE_LEFT)));

  assign w_pop        = !w_fifo_empty && (r_cnt_wait == CNT_WAIT_MAX - 16'd1);
  assign w_drain_done = (r_state == DRAIN) && w_fifo_empty && !r_lo_vld && !r_tx_flag;

  sdr_byte_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .i_clk    (i_sys_clk),
    .i_rst_n  (i_sys_rst_n),
    .i_flush  (w_timeout),
    .i_push_a (w_push_a),
    .i_data_a (w_data_a),
    .i_push_b (w_push_b),
    .i_data_b (w_data_b),
    .i_pop    (w_pop),
    .o_data   (w_fifo_data),
    .o_empty  (w_fifo_empty),
    .o_full   (w_fifo_full),
    .o_count  (w_fifo_count)
  );

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state and done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = REQ;
      REQ:   w_state_nxt = WAIT;
      WAIT:  begin
        if (i_rd_busy)          w_state_nxt = RECV;
        else if (r_tmo == '0)   w_state_nxt = IDLE;
      end
      RECV:  if (w_fall) w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_drain_done) begin
          w_done = 1'b1;
`ifdef SDR_AUTO_INC_EN
          w_state_nxt = (r_stop || r_err) ? IDLE : REQ;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sector address, busy timeout and per-sector word count.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_rd_addr  <= '0;
      r_tmo      <= '0;
      r_word_cnt <= '0;
      r_busy_d   <= 1'b0;
    end else begin
      r_busy_d <= i_rd_busy;
      if (w_accept) r_rd_addr <= i_start_addr;
`ifdef SDR_AUTO_INC_EN
      else if (w_drain_done && !r_stop && !r_err) r_rd_addr <= r_rd_addr + 32'd1;
`endif
      if (r_state == REQ)                       r_tmo <= BUSY_TIMEOUT - 24'd1;
      else if (r_state == WAIT && r_tmo != '0)  r_tmo <= r_tmo - 24'd1;
      if (r_state == REQ) r_word_cnt <= '0;
      else if (w_word_en) r_word_cnt <= w_wcnt_nxt;
    end
  end

  // Low-byte holding register of the word splitter.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_lo     <= '0;
      r_lo_vld <= 1'b0;
    end else begin
      r_lo_vld <= w_word_en;
      if (w_word_en) r_lo <= i_rd_data[7:0];
    end
  end

  // UART pacing: one byte every CNT_WAIT_MAX cycles while data is buffered.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_cnt_wait <= '0;
      r_tx_flag  <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_fifo_empty || w_pop) r_cnt_wait <= '0;
      else                       r_cnt_wait <= r_cnt_wait + 16'd1;
      r_tx_flag <= w_pop;
      if (w_pop) r_tx_data <= w_fifo_data;
    end
  end

  // Sticky error, cleared only by an accepted start.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)                            r_err <= 1'b0;
    else if (w_accept)                           r_err <= 1'b0;
    else if (w_timeout || w_cnt_bad || w_drop)   r_err <= 1'b1;
  end

`ifdef SDR_AUTO_INC_EN
  // A start pulse while busy requests a stop after the current sector.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)                        r_stop <= 1'b0;
    else if (w_accept)                       r_stop <= 1'b0;
    else if (r_state != IDLE && i_start)     r_stop <= 1'b1;
  end
`endif

  assign o_rd_en   = (r_state == REQ);
  assign o_rd_addr = r_rd_addr;
  assign o_tx_flag = r_tx_flag;
  assign o_tx_data = r_tx_data;
  assign o_busy    = (r_state != IDLE);
  assign o_done    = w_done;
  assign o_err     = r_err;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: a table of sector-read scenarios driven through
// a small SD controller model, with expected bytes queued as words are sent
// and popped as o_tx_flag strobes appear; plus hand-written sequences for
// busy timeout, reset mid-read and (when enabled) auto-increment.
module tb_sd_sector_reader;

  localparam logic [15:0] CNT_WAIT = 16'd16;
  localparam logic [23:0] TMO      = 24'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_init_end = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_start_addr = '0;
  logic        i_rd_busy = 1'b0;
  logic        i_rd_data_en = 1'b0;
  logic [15:0] i_rd_data = '0;
  logic        o_rd_en, o_tx_flag, o_busy, o_done, o_err;
  logic [31:0] o_rd_addr;
  logic [7:0]  o_tx_data;

  sd_sector_reader #(
    .WORDS_PER_SECTOR (256),
    .BUF_DEPTH        (512),
    .CNT_WAIT_MAX     (CNT_WAIT),
    .BUSY_TIMEOUT     (TMO)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_init_end   (i_init_end),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_busy    (i_rd_busy),
    .i_rd_data_en (i_rd_data_en),
    .i_rd_data    (i_rd_data),
    .o_tx_flag    (o_tx_flag),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        init;
    logic [31:0] addr;
    int          nwords;
    int          gap;
    int          mid_k;
    logic        exp_rd_en;
    logic        exp_err;
    int          exp_bytes;
  } vec_t;

  vec_t        tbl [5];
  int          checks = 0;
  int          errors = 0;
  int          rd_en_cnt = 0;
  int          done_cnt = 0;
  int          tx_cnt = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  logic        ignore_tx = 1'b0;
  logic        have_prev = 1'b0;
  longint      cyc = 0;
  longint      prev_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({o_rd_en, o_busy, o_done, o_err, o_tx_flag, o_tx_data, o_rd_addr});
  endfunction

  // Monitor: counts events and scores transmitted bytes against the queue.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (o_rd_en) rd_en_cnt++;
      if (o_done)  done_cnt++;
      if (o_tx_flag) begin
        tx_cnt++;
        if (!ignore_tx) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_extra got=%02h expected=none", o_tx_data);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("tx_data", 64'(o_tx_data), 64'(mon_exp));
          end
          if (have_prev) chk("tx_spacing", 64'(cyc - prev_cyc), 64'd16);
          prev_cyc  = cyc;
          have_prev = 1'b1;
        end
      end
    end
  end

  task automatic pulse_start(input logic init, input logic [31:0] addr);
    @(posedge clk); #1;
    i_init_end   = init;
    i_start      = 1'b1;
    i_start_addr = addr;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_rd_en(input int bound, output logic ok, output logic [31:0] addr);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_rd_en) begin
        ok   = 1'b1;
        addr = o_rd_addr;
        break;
      end
    end
  endtask

  // Called at the negedge of the rd_en cycle; returns with the DUT in RECV.
  task automatic begin_read();
    @(posedge clk); #1;
    i_rd_busy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_words(input int n, input int gap, input int mid_k, input logic push_exp);
    for (int i = 0; i < n; i++) begin
      if (i == mid_k) begin
        i_start      = 1'b1;
        i_start_addr = 32'h0000_5555;
      end
      i_rd_data_en = 1'b1;
      i_rd_data    = 16'(i + 1);
      if (push_exp) begin
        exp_q.push_back(8'((i + 1) >> 8));
        exp_q.push_back(8'(i + 1));
      end
      @(posedge clk); #1;
      i_rd_data_en = 1'b0;
      i_start      = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_counts();
    rd_en_cnt = 0;
    done_cnt  = 0;
    tx_cnt    = 0;
    have_prev = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic        ok;
    logic [31:0] a;
    int          n;
    int          mk;
    int          t0;

    tbl[0] = '{1'b1, 32'd1000,       256, 1, -1,  1'b1, 1'b0, 512};
    tbl[1] = '{1'b1, 32'd42,         200, 2, -1,  1'b1, 1'b1, 400};
    tbl[2] = '{1'b0, 32'd77,           0, 0, -1,  1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 32'hDEAD_BEEF,  256, 0, 100, 1'b1, 1'b0, 512};
    tbl[4] = '{1'b1, 32'd5,            1, 0, -1,  1'b1, 1'b1, 2};

    // Reset values, during and just after reset.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_outputs", outs(), 64'd0);

    // Busy timeout: rd_busy never rises.
    clear_counts();
    pulse_start(1'b1, 32'd9);
    wait_rd_en(10, ok, a);
    chk("tmo_rd_en", 64'(ok), 64'd1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n = i + 1;
      if (o_err) break;
    end
    // err appears after the 100 WAIT cycles that follow the REQ cycle.
    chk("tmo_err_latency", 64'(n), 64'd101);
    chk("tmo_busy", 64'(o_busy), 64'd0);
    repeat (50) @(negedge clk);
    chk("tmo_err_sticky", 64'(o_err), 64'd1);
    chk("tmo_no_tx", 64'(tx_cnt), 64'd0);
    chk("tmo_no_done", 64'(done_cnt), 64'd0);
    chk("tmo_one_rd_en", 64'(rd_en_cnt), 64'd1);

    // Table of sector-read scenarios.
    for (int v = 0; v < 5; v++) begin
      clear_counts();
      mk = tbl[v].mid_k;
`ifdef SDR_AUTO_INC_EN
      if (mk < 0) mk = 0;
`endif
      pulse_start(tbl[v].init, tbl[v].addr);
      if (!tbl[v].exp_rd_en) begin
        repeat (30) @(negedge clk);
        chk("guard_no_rd_en", 64'(rd_en_cnt), 64'd0);
        chk("guard_not_busy", 64'(o_busy), 64'd0);
        chk("guard_no_tx", 64'(tx_cnt), 64'd0);
      end else begin
        wait_rd_en(10, ok, a);
        chk("vec_rd_en", 64'(ok), 64'd1);
        chk("vec_rd_addr", 64'(a), 64'(tbl[v].addr));
        begin_read();
        send_words(tbl[v].nwords, tbl[v].gap, mk, 1'b1);
        i_rd_busy = 1'b0;
        wait_done(tbl[v].exp_bytes * 16 + 600, ok);
        chk("vec_done_seen", 64'(ok), 64'd1);
        repeat (5) @(negedge clk);
        chk("vec_rd_en_count", 64'(rd_en_cnt), 64'd1);
        chk("vec_done_count", 64'(done_cnt), 64'd1);
        chk("vec_err", 64'(o_err), 64'(tbl[v].exp_err));
        chk("vec_tx_count", 64'(tx_cnt), 64'(tbl[v].exp_bytes));
        chk("vec_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("vec_busy_low", 64'(o_busy), 64'd0);
        chk("vec_addr_held", 64'(o_rd_addr), 64'(tbl[v].addr));
      end
    end

    // Reset in the middle of RECV with bytes already on their way out.
    clear_counts();
    ignore_tx = 1'b1;
    pulse_start(1'b1, 32'd300);
    wait_rd_en(10, ok, a);
    chk("rst_rd_en", 64'(ok), 64'd1);
    begin_read();
    send_words(30, 1, -1, 1'b0);
    chk("rst_pre_busy", 64'(o_busy), 64'd1);
    chk("rst_pre_tx", 64'(tx_cnt > 0), 64'd1);
    rst_n = 1'b0;
    #1 chk("rst_mid_outputs", outs(), 64'd0);
    i_rd_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    t0 = tx_cnt;
    repeat (100) @(negedge clk);
    chk("rst_no_tx_after", 64'(tx_cnt), 64'(t0));
    chk("rst_outputs_after", outs(), 64'd0);
    ignore_tx = 1'b0;

`ifdef SDR_AUTO_INC_EN
    // Consecutive sectors 7, 8, 9; a start pulse during sector 9 stops it.
    clear_counts();
    pulse_start(1'b1, 32'd7);
    for (int s = 0; s < 3; s++) begin
      wait_rd_en(20000, ok, a);
      chk("ai_rd_en", 64'(ok), 64'd1);
      chk("ai_rd_addr", 64'(a), 64'(7 + s));
      begin_read();
      have_prev = 1'b0;
      send_words(256, 1, (s == 2) ? 10 : -1, 1'b1);
      i_rd_busy = 1'b0;
    end
    wait_done(9000, ok);
    chk("ai_last_done", 64'(ok), 64'd1);
    repeat (50) @(negedge clk);
    chk("ai_rd_en_count", 64'(rd_en_cnt), 64'd3);
    chk("ai_done_count", 64'(done_cnt), 64'd3);
    chk("ai_tx_count", 64'(tx_cnt), 64'd1536);
    chk("ai_busy_low", 64'(o_busy), 64'd0);
    chk("ai_err", 64'(o_err), 64'd0);
    chk("ai_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
